// File: rtl/sum_map_seq_if.sv
// Issuer handshake plus state-RAM read/write port bundle for sum_map_seq.
// The sequencer connects through the slave modport; the issuer/RAM side uses master.
interface sum_map_seq_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] origin;
    logic [ADDR_W-1:0] modifier;
    logic [LEN_W-1:0]  length;
    logic              cond_ok;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [ADDR_W-1:0] rd_b_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_a_data;
    logic [DATA_W-1:0] rd_b_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output start, origin, modifier, length, cond_ok, rd_a_data, rd_b_data,
        input  busy, done, rd_a_addr, rd_b_addr, rd_en, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, origin, modifier, length, cond_ok, rd_a_data, rd_b_data,
        output busy, done, rd_a_addr, rd_b_addr, rd_en, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/sum_map_seq.sv
// Sequencer that computes state[origin+i] += state[modifier+i] for i = 0..length-1,
// one word per cycle, with the exact results of the equivalent sequential loop.
module sum_map_seq #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    sum_map_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] origin_q, origin_d;
    logic [ADDR_W-1:0] modifier_q, modifier_d;
    logic [LEN_W-1:0]  length_q, length_d;
    logic [LEN_W-1:0]  idx_q, idx_d;

    logic              wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              fwd_a_q, fwd_a_d;
    logic              fwd_b_q, fwd_b_d;
    logic [DATA_W-1:0] fwd_val_q, fwd_val_d;

    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            origin_q   <= '0;
            modifier_q <= '0;
            length_q   <= '0;
            idx_q      <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            fwd_a_q    <= 1'b0;
            fwd_b_q    <= 1'b0;
            fwd_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            origin_q   <= origin_d;
            modifier_q <= modifier_d;
            length_q   <= length_d;
            idx_q      <= idx_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            fwd_val_q  <= fwd_val_d;
        end
    end

    // Read-issue FSM
    always_comb begin
        state_d    = state_q;
        origin_d   = origin_q;
        modifier_d = modifier_q;
        length_d   = length_q;
        idx_d      = idx_q;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_a_addr  = '0;
        rd_b_addr  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    origin_d   = bus.origin;
                    modifier_d = bus.modifier;
                    length_d   = bus.length;
                    idx_d      = '0;
                    if (!bus.cond_ok || (bus.length == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                rd_a_addr = origin_q + ADDR_W'(idx_q);
                rd_b_addr = modifier_q + ADDR_W'(idx_q);
                idx_d     = idx_q + LEN_W'(1);
                if (idx_q == length_q - LEN_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The RAM returns pre-write data when a read collides with the write in the same
    // cycle, so the written value is captured and substituted on the next cycle.
    always_comb begin
        op_a      = fwd_a_q ? fwd_val_q : bus.rd_a_data;
        op_b      = fwd_b_q ? fwd_val_q : bus.rd_b_data;
        sum       = op_a + op_b;
        wr_pend_d = rd_en;
        wr_addr_d = rd_a_addr;
        fwd_a_d   = rd_en && wr_pend_q && (rd_a_addr == wr_addr_q);
        fwd_b_d   = rd_en && wr_pend_q && (rd_b_addr == wr_addr_q);
        fwd_val_d = sum;
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rd_en     = rd_en;
    assign bus.rd_a_addr = rd_a_addr;
    assign bus.rd_b_addr = rd_b_addr;
    assign bus.wr_en     = wr_pend_q;
    assign bus.wr_addr   = wr_pend_q ? wr_addr_q : '0;
    assign bus.wr_data   = wr_pend_q ? sum : '0;
endmodule

// File: tb/tb_sum_map_seq.sv
// Self-checking bench for sum_map_seq: RAM model on the bus, loop-level reference model.
module tb_sum_map_seq;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sum_map_seq_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    sum_map_seq #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous RAM: reads return pre-write contents; bench preload has priority.
    logic [DW-1:0] mem [0:255];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        if (bus.rd_en) begin
            bus.rd_a_data <= mem[bus.rd_a_addr];
            bus.rd_b_data <= mem[bus.rd_b_addr];
        end
    end

    logic [DW-1:0] ref_mem [0:255];
    logic [AW-1:0] wr_q[$];
    logic [AW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int rd_cnt, done_cnt, lat;
    logic done_after, busy_after;

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Plain sequential loop over the reference memory image.
    function automatic void ref_apply(input logic [AW-1:0] o, input logic [AW-1:0] m,
                                      input logic [LW-1:0] len, input logic c);
        logic [AW-1:0] a, b;
        exp_q.delete();
        if (!c) return;
        for (int i = 0; i < int'(len); i++) begin
            a = AW'(int'(o) + i);
            b = AW'(int'(m) + i);
            ref_mem[a] = ref_mem[a] + ref_mem[b];
            exp_q.push_back(a);
        end
    endfunction

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    function automatic int order_diffs();
        int n = 0;
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    // Spec latency counts to the edge that samples done; lat counts edges to done becoming visible.
    function automatic int exp_lat(input logic [LW-1:0] len, input logic c);
        return ((c && len != 0) ? int'(len) + 2 : 1) - 1;
    endfunction

    // Launch one operation and record every cycle until done (bounded).
    task automatic run_op(input logic [AW-1:0] o, input logic [AW-1:0] m,
                          input logic [LW-1:0] len, input logic c, input bit intrude);
        wr_q.delete(); rd_cnt = 0; done_cnt = 0; lat = -1;
        bus.start = 1'b1; bus.origin = o; bus.modifier = m; bus.length = len; bus.cond_ok = c;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (intrude) begin
                bus.start  = (cyc == 2 || cyc == 3);
                bus.origin = o + 8'd40;
            end
            if (bus.rd_en) rd_cnt++;
            if (bus.wr_en) wr_q.push_back(bus.wr_addr);
            if (bus.done) begin
                done_cnt++;
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        done_after = bus.done;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if ({bus.rd_en, bus.wr_en} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {bus.rd_en, bus.wr_en}); end
        checks++; if ({bus.rd_a_addr, bus.rd_b_addr, bus.wr_addr} !== 24'h0) begin errors++; $display("FAIL reset_addrs: got %h expected 0", {bus.rd_a_addr, bus.rd_b_addr, bus.wr_addr}); end
        checks++; if (bus.wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", bus.wr_data); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        load_word(8'd10, 32'd5); load_word(8'd11, 32'd7); load_word(8'd12, 32'd9);
        load_word(8'd20, 32'd1); load_word(8'd21, 32'd2); load_word(8'd22, 32'd3);
        ref_apply(8'd10, 8'd20, 8'd3, 1'b1);
        run_op(8'd10, 8'd20, 8'd3, 1'b1, 1'b0);
        checks++; if ({mem[10], mem[11], mem[12]} !== {32'd6, 32'd9, 32'd12}) begin errors++; $display("FAIL basic_values: got %0d %0d %0d expected 6 9 12", mem[10], mem[11], mem[12]); end
        checks++; if (wr_q.size() != 3) begin errors++; $display("FAIL basic_wr_count: got %0d expected 3", wr_q.size()); end
        checks++; if (order_diffs() != 0) begin errors++; $display("FAIL basic_wr_order: got %0d misordered expected 0", order_diffs()); end
        checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        checks++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done_after, busy_after); end
        checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL basic_mem: got %0d diffs expected 0", mem_diffs()); end
    endtask

    task automatic test_skip();
        for (int k = 0; k < 2; k++) begin
            logic [LW-1:0] len = (k == 0) ? 8'd3 : 8'd0;
            logic          c   = (k == 0) ? 1'b0 : 1'b1;
            ref_apply(8'd10, 8'd20, len, c);
            run_op(8'd10, 8'd20, len, c, 1'b0);
            checks++; if (rd_cnt != 0 || wr_q.size() != 0) begin errors++; $display("FAIL skip%0d_access: got rd=%0d wr=%0d expected 0 0", k, rd_cnt, wr_q.size()); end
            checks++; if (lat != exp_lat(len, c)) begin errors++; $display("FAIL skip%0d_latency: got %0d expected %0d", k, lat, exp_lat(len, c)); end
            checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL skip%0d_mem: got %0d diffs expected 0", k, mem_diffs()); end
        end
    endtask

    task automatic test_overflow();
        load_word(8'd0, 32'hFFFF_FFFF); load_word(8'd1, 32'd2);
        ref_apply(8'd0, 8'd1, 8'd1, 1'b1);
        run_op(8'd0, 8'd1, 8'd1, 1'b1, 1'b0);
        checks++; if (mem[0] !== 32'h0000_0001) begin errors++; $display("FAIL overflow: got %h expected 00000001", mem[0]); end
        checks++; if (lat != 2) begin errors++; $display("FAIL overflow_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_forwarding();
        for (int i = 4; i < 8; i++) load_word(AW'(i), 32'd1);
        ref_apply(8'd5, 8'd4, 8'd3, 1'b1);
        run_op(8'd5, 8'd4, 8'd3, 1'b1, 1'b0);
        checks++; if ({mem[5], mem[6], mem[7]} !== {32'd2, 32'd3, 32'd4}) begin errors++; $display("FAIL forwarding: got %0d %0d %0d expected 2 3 4", mem[5], mem[6], mem[7]); end
        checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL forwarding_mem: got %0d diffs expected 0", mem_diffs()); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addrs;
        ref_apply(8'hFE, 8'h10, 8'd4, 1'b1);
        run_op(8'hFE, 8'h10, 8'd4, 1'b1, 1'b0);
        exp_addrs = 32'hFEFF_0001;
        checks++; if (wr_q.size() != 4 || {wr_q[0], wr_q[1], wr_q[2], wr_q[3]} !== exp_addrs) begin errors++; $display("FAIL wrap_order: got %0d writes expected FE FF 00 01", wr_q.size()); end
        checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL wrap_mem: got %0d diffs expected 0", mem_diffs()); end
    endtask

    task automatic test_start_during_busy();
        int extra_busy = 0;
        ref_apply(8'd30, 8'd60, 8'd5, 1'b1);
        run_op(8'd30, 8'd60, 8'd5, 1'b1, 1'b1);
        repeat (8) begin
            if (bus.busy || bus.done) extra_busy++;
            @(posedge clk); #1;
        end
        checks++; if (done_cnt != 1 || extra_busy != 0) begin errors++; $display("FAIL busy_start: got done=%0d extra_busy=%0d expected 1 0", done_cnt, extra_busy); end
        checks++; if (wr_q.size() != 5 || mem_diffs() != 0) begin errors++; $display("FAIL busy_start_mem: got wr=%0d diffs=%0d expected 5 0", wr_q.size(), mem_diffs()); end
    endtask

    task automatic test_back_to_back();
        ref_apply(8'd70, 8'd71, 8'd6, 1'b1);
        run_op(8'd70, 8'd71, 8'd6, 1'b1, 1'b0);
        checks++; if (lat != exp_lat(8'd6, 1'b1)) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, exp_lat(8'd6, 1'b1)); end
        ref_apply(8'd73, 8'd70, 8'd4, 1'b1);
        run_op(8'd73, 8'd70, 8'd4, 1'b1, 1'b0);
        checks++; if (lat != exp_lat(8'd4, 1'b1)) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, exp_lat(8'd4, 1'b1)); end
        checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL b2b_mem: got %0d diffs expected 0", mem_diffs()); end
    endtask

    task automatic test_random();
        int bad_lat = 0, bad_wr = 0, bad_mem = 0;
        for (int i = 0; i < 256; i++) load_word(AW'(i), $urandom);
        for (int n = 0; n < 25; n++) begin
            logic [AW-1:0] o   = AW'($urandom);
            logic [AW-1:0] m   = ($urandom_range(0, 1) == 1) ? o - AW'($urandom_range(0, 3)) : AW'($urandom);
            logic [LW-1:0] len = LW'($urandom_range(0, 24));
            logic          c   = ($urandom_range(0, 4) != 0);
            ref_apply(o, m, len, c);
            run_op(o, m, len, c, 1'b0);
            if (lat != exp_lat(len, c)) bad_lat++;
            if (wr_q.size() != exp_q.size() || order_diffs() != 0) bad_wr++;
            if (mem_diffs() != 0) bad_mem++;
        end
        checks++; if (bad_lat != 0) begin errors++; $display("FAIL random_latency: got %0d bad ops expected 0", bad_lat); end
        checks++; if (bad_wr != 0) begin errors++; $display("FAIL random_writes: got %0d bad ops expected 0", bad_wr); end
        checks++; if (bad_mem != 0) begin errors++; $display("FAIL random_mem: got %0d bad ops expected 0", bad_mem); end
    endtask

    task automatic test_reset_midop();
        int late_wr = 0, late_done = 0, late_busy = 0;
        bus.start = 1'b1; bus.origin = 8'd100; bus.modifier = 8'd50; bus.length = 8'd10; bus.cond_ok = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL midop_active: got wr_en=%b expected 1", bus.wr_en); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midop_abort: got wr_en=%b busy=%b expected 0 0", bus.wr_en, bus.busy); end
        rst = 1'b0;
        repeat (20) begin
            if (bus.wr_en) late_wr++;
            if (bus.done) late_done++;
            if (bus.busy) late_busy++;
            @(posedge clk); #1;
        end
        checks++; if (late_wr != 0 || late_done != 0 || late_busy != 0) begin errors++; $display("FAIL midop_quiet: got wr=%0d done=%0d busy=%0d expected 0 0 0", late_wr, late_done, late_busy); end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.origin = '0; bus.modifier = '0; bus.length = '0; bus.cond_ok = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 'x;
        test_reset();
        for (int i = 0; i < 256; i++) load_word(AW'(i), 32'd0);
        test_basic();
        test_skip();
        test_overflow();
        test_forwarding();
        test_wrap();
        test_start_during_busy();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sum_map_seq.md
Name: sum_map_seq

Overview:
- Multi-cycle sequencer that undoes a difference map over the u32 execution-environment state.
- For i = 0..length-1 it computes state[origin+i] = state[origin+i] + state[modifier+i], in order, one word per cycle.
- Results equal a sequential software loop, including overlapping ranges.
- Sits beside the operation decoder, drives the state RAM's two read ports and one write port, and handshakes with the instruction issuer via start/busy/done.

Parameters:
- ADDR_W, 8, word-address width of state RAM.
- DATA_W, 32, word width.
- LEN_W, 8, width of length field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- origin  in  ADDR_W  base of destination/first-operand range.
- modifier  in  ADDR_W  base of second-operand range.
- length  in  LEN_W  word count.
- cond_ok  in  1  pre-evaluated single-flag condition; 0 = skip.
- busy  out  1  high in RUN, DRAIN and DONE.
- done  out  1  one-cycle completion pulse.
- rd_a_addr  out  ADDR_W  read port A address (origin side).
- rd_b_addr  out  ADDR_W  read port B address (modifier side).
- rd_en  out  1  read strobe for both ports.
- rd_a_data  in  DATA_W  port A data, valid 1 cycle after rd_en.
- rd_b_data  in  DATA_W  port B data, valid 1 cycle after rd_en.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, all address/data outputs 0, state=IDLE, index=0.
- rst has priority over every other input. Reset mid-operation aborts immediately; no further writes are issued.
- State machine: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1, latch origin, modifier, length and cond_ok.
  - If cond_ok=0 or length=0, go to DONE. No memory access occurs.
  - Otherwise go to RUN with index=0.
- RUN:
  - Each cycle: rd_en=1, rd_a_addr=origin_l+index, rd_b_addr=modifier_l+index; index increments.
  - After issuing index=length_l-1, go to DRAIN.
- Write stage: in the cycle after read i is issued, wr_en=1, wr_addr=origin_l+i, wr_data=(A+B) mod 2^DATA_W. Carry is discarded.
- DRAIN: performs the final write, then goes to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored while busy=1.
- Address arithmetic is modulo 2^ADDR_W (wrap from max address to 0).
- Forwarding:
  - The RAM returns old data on read-during-write to the same address.
  - If a read issued in cycle k targets (on either port) the address written in cycle k, the block latches wr_data.
  - In cycle k+1 it uses the latched value in place of the corresponding rd_*_data.
  - This preserves sequential-loop semantics, e.g. for modifier = origin-1.
- origin == modifier: each word doubles; no special case.
- Latency:
  - Normal operation: done asserts length+2 cycles after the start-sampling edge.
  - Skip case (cond_ok=0 or length=0): done asserts 1 cycle after.

Test Plan:
- Basic: mem[10..12]={5,7,9}, mem[20..22]={1,2,3}, origin=10, modifier=20, length=3, cond_ok=1 -> mem[10..12]={6,9,12}; exactly 3 writes; done at cycle 5.
- Skip: same setup with cond_ok=0 -> no rd_en/wr_en; done 1 cycle after start; memory unchanged. Repeat with length=0 and cond_ok=1 -> same result.
- Overflow: mem[0]=0xFFFFFFFF, mem[1]=2, origin=0, modifier=1, length=1 -> mem[0]=0x00000001.
- Forwarding: mem[4..7]={1,1,1,1}, origin=5, modifier=4, length=3 -> mem[5..7]={2,3,4}. A non-forwarding design would give {2,2,2}.
- Wrap: ADDR_W=8, origin=0xFE, modifier=0x10, length=4 -> writes go to 0xFE, 0xFF, 0x00, 0x01, in order.
- Reset mid-op: length=10, assert rst at cycle 4 -> from the next cycle wr_en=0, busy=0, done never pulses. start during busy on a separate run -> ignored, with one done per accepted start.
